// File: rtl/g0_chain_search_ctrl.sv
// Search/update sequencer for one G0 lookup table: walks the linked entry chain
// for each search and shares the table's single index/write port with rule updates.
module g0_chain_search_ctrl #(
    parameter int INDEX_BIT_LEN    = 11,
    parameter int PACKET_BIT_LEN   = 104,
    parameter int ENTRY_DATA_WIDTH = 171,
    parameter int MAX_HOPS         = 16,
    parameter int UPD_BURST        = 4,
    parameter int NULL_INDEX       = 0,
    parameter int HOP_W            = $clog2(MAX_HOPS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        srch_valid,
    output logic                        srch_ready,
    input  logic [PACKET_BIT_LEN-1:0]   srch_tuple,
    input  logic [INDEX_BIT_LEN-1:0]    srch_start,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [INDEX_BIT_LEN-1:0]    upd_index,
    input  logic [ENTRY_DATA_WIDTH-1:0] upd_data,
    output logic [INDEX_BIT_LEN-1:0]    tbl_index,
    output logic [PACKET_BIT_LEN-1:0]   tbl_tuple,
    output logic                        tbl_we,
    output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
    input  logic                        tbl_match,
    input  logic [INDEX_BIT_LEN-1:0]    tbl_rule_id,
    input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index,
    output logic                        res_valid,
    output logic                        res_hit,
    output logic [INDEX_BIT_LEN-1:0]    res_rule_id,
    output logic [HOP_W-1:0]            res_hops,
    output logic                        res_timeout,
    output logic                        busy
);

    localparam int STREAK_W = $clog2(UPD_BURST + 1);
    localparam logic [HOP_W-1:0]         MAX_HOPS_C = HOP_W'(MAX_HOPS);
    localparam logic [STREAK_W-1:0]      BURST_C    = STREAK_W'(UPD_BURST);
    localparam logic [INDEX_BIT_LEN-1:0] NULL_C     = INDEX_BIT_LEN'(NULL_INDEX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [INDEX_BIT_LEN-1:0]    tbl_index_q, tbl_index_d;
    logic [PACKET_BIT_LEN-1:0]   tbl_tuple_q, tbl_tuple_d;
    logic                        tbl_we_q, tbl_we_d;
    logic [ENTRY_DATA_WIDTH-1:0] tbl_din_q, tbl_din_d;
    logic                        res_valid_q, res_valid_d;
    logic                        res_hit_q, res_hit_d;
    logic [INDEX_BIT_LEN-1:0]    res_rule_id_q, res_rule_id_d;
    logic [HOP_W-1:0]            res_hops_q, res_hops_d;
    logic                        res_timeout_q, res_timeout_d;
    logic [HOP_W-1:0]            hops_q, hops_d;
    logic [STREAK_W-1:0]         streak_q, streak_d;

    logic idle;
    logic chain_end;

    assign idle = (state_q == S_IDLE);

    // An update yields to a waiting search once it has won UPD_BURST times in a row.
    assign upd_ready  = idle && upd_valid && (!srch_valid || (streak_q < BURST_C));
    assign srch_ready = idle && !upd_ready;
    assign busy       = !idle;

    assign chain_end = tbl_match || (tbl_next_index == NULL_C) || (hops_q == MAX_HOPS_C);

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        state_d       = state_q;
        tbl_index_d   = tbl_index_q;
        tbl_tuple_d   = tbl_tuple_q;
        tbl_we_d      = 1'b0;
        tbl_din_d     = tbl_din_q;
        res_valid_d   = 1'b0;
        res_hit_d     = res_hit_q;
        res_rule_id_d = res_rule_id_q;
        res_hops_d    = res_hops_q;
        res_timeout_d = res_timeout_q;
        hops_d        = hops_q;
        streak_d      = streak_q;

        unique case (state_q)
            S_IDLE: begin
                if (upd_valid && upd_ready) begin
                    state_d     = S_UPD;
                    tbl_we_d    = 1'b1;
                    tbl_index_d = upd_index;
                    tbl_din_d   = upd_data;
                    // Arbitration stops granting at UPD_BURST, so this cannot overrun.
                    streak_d    = srch_valid ? streak_q + STREAK_W'(1) : '0;
                end else if (srch_valid && srch_ready) begin
                    state_d     = S_ISSUE;
                    tbl_index_d = srch_start;
                    tbl_tuple_d = srch_tuple;
                    hops_d      = '0;
                    streak_d    = '0;
                end else if (!srch_valid) begin
                    streak_d = '0;
                end
            end
            S_UPD: state_d = S_IDLE;
            S_ISSUE: begin
                hops_d  = hops_q + HOP_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (chain_end) begin
                    state_d       = S_DONE;
                    res_valid_d   = 1'b1;
                    res_hit_d     = tbl_match;
                    res_rule_id_d = tbl_match ? tbl_rule_id : '0;
                    res_hops_d    = hops_q;
                    res_timeout_d = !tbl_match && (tbl_next_index != NULL_C);
                end else begin
                    tbl_index_d = tbl_next_index;
                    state_d     = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tbl_index_q   <= '0;
            tbl_tuple_q   <= '0;
            tbl_we_q      <= 1'b0;
            tbl_din_q     <= '0;
            res_valid_q   <= 1'b0;
            res_hit_q     <= 1'b0;
            res_rule_id_q <= '0;
            res_hops_q    <= '0;
            res_timeout_q <= 1'b0;
            hops_q        <= '0;
            streak_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q       <= state_d;
            tbl_index_q   <= tbl_index_d;
            tbl_tuple_q   <= tbl_tuple_d;
            tbl_we_q      <= tbl_we_d;
            tbl_din_q     <= tbl_din_d;
            res_valid_q   <= res_valid_d;
            res_hit_q     <= res_hit_d;
            res_rule_id_q <= res_rule_id_d;
            res_hops_q    <= res_hops_d;
            res_timeout_q <= res_timeout_d;
            hops_q        <= hops_d;
            streak_q      <= streak_d;
        end
    end

    assign tbl_index   = tbl_index_q;
    assign tbl_tuple   = tbl_tuple_q;
    assign tbl_we      = tbl_we_q;
    assign tbl_din     = tbl_din_q;
    assign res_valid   = res_valid_q;
    assign res_hit     = res_hit_q;
    assign res_rule_id = res_rule_id_q;
    assign res_hops    = res_hops_q;
    assign res_timeout = res_timeout_q;

endmodule

// File: doc/g0_chain_search_ctrl.md
Name: g0_chain_search_ctrl

Overview:
Sequencer for one small-segment/G0 lookup table instance. It accepts packet search requests and walks the table's linked entry chain (start index, then next_index hops) until it gets a match, a null link or a hop limit. It also accepts rule-update writes and shares the table's single index/write port between the two. It sits between the subset's request distributor and the table, and drives the table's index, tuple, write-enable and write-data inputs.

Parameters:
INDEX_BIT_LEN, 11, table index and ruleID width
PACKET_BIT_LEN, 104, 5-tuple width
ENTRY_DATA_WIDTH, 171, table entry width
MAX_HOPS, 16, maximum lookups per search (>=1)
UPD_BURST, 4, maximum consecutive update grants while a search is waiting (>=1)
NULL_INDEX, 0, next_index value that terminates a chain
HOP_W, $clog2(MAX_HOPS+1), width of the hop count

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
srch_valid  in  1  search request valid
srch_ready  out  1  search accepted when srch_valid & srch_ready
srch_tuple  in  PACKET_BIT_LEN  packet 5-tuple
srch_start  in  INDEX_BIT_LEN  chain head index
upd_valid  in  1  update request valid
upd_ready  out  1  update accepted when upd_valid & upd_ready
upd_index  in  INDEX_BIT_LEN  entry to write
upd_data  in  ENTRY_DATA_WIDTH  entry contents
tbl_index  out  INDEX_BIT_LEN  table search/write index (registered)
tbl_tuple  out  PACKET_BIT_LEN  tuple presented to table (registered)
tbl_we  out  1  table write enable (registered)
tbl_din  out  ENTRY_DATA_WIDTH  table write data (registered)
tbl_match  in  1  table match result, valid 1 cycle after tbl_index is sampled
tbl_rule_id  in  INDEX_BIT_LEN  table ruleID
tbl_next_index  in  INDEX_BIT_LEN  table next-entry link
res_valid  out  1  one-cycle result pulse
res_hit  out  1  1 = match found
res_rule_id  out  INDEX_BIT_LEN  matched ruleID; 0 on miss
res_hops  out  HOP_W  lookups performed (1..MAX_HOPS)
res_timeout  out  1  walk ended because MAX_HOPS was reached
busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous when rst_n=0. It applies at any state, including mid-walk or mid-update, and discards the in-flight request with no result:
  - state goes to IDLE;
  - every registered output is cleared to 0: tbl_index, tbl_tuple, tbl_we, tbl_din, res_*;
  - hop counter and update streak counter are cleared to 0.
- States and transitions:
  - IDLE -> UPD on update accept.
  - IDLE -> ISSUE on search accept.
  - UPD -> IDLE.
  - ISSUE -> WAIT.
  - WAIT -> ISSUE or DONE.
  - DONE -> IDLE.
- srch_ready and upd_ready are combinational. Both are 0 outside IDLE, and at most one is 1 in a cycle.
- Arbitration in IDLE:
  - If only one request is valid, it is granted.
  - If both are valid, update wins while streak < UPD_BURST; otherwise search wins.
- Streak counter:
  - increments on an update grant while srch_valid=1;
  - clears on a search grant, or in any IDLE cycle with srch_valid=0;
  - saturates at UPD_BURST.
- Update accept:
  - the next cycle (UPD) has tbl_we=1, tbl_index=upd_index, tbl_din=upd_data;
  - tbl_we returns to 0 the following cycle;
  - an update occupies 2 cycles.
- Search accept:
  - tuple is latched; cur = srch_start; hops = 0.
- ISSUE:
  - tbl_index=cur and tbl_tuple=latched tuple; tbl_we=0.
  - hops increments.
- WAIT: table outputs are sampled.
  - If tbl_match=1: hit, rule = tbl_rule_id.
  - Else if tbl_next_index == NULL_INDEX: miss.
  - Else if hops == MAX_HOPS: miss with res_timeout=1.
  - Else cur = tbl_next_index and go to ISSUE.
  - Match takes priority over null link and timeout.
- DONE:
  - res_valid=1 for exactly one cycle, with res_hit, res_rule_id, res_hops and res_timeout.
  - The result fields hold their values until the next result.
  - There is no result backpressure.
- Latency:
  - a search resolved in N hops gives res_valid 2N+1 cycles after the accept edge;
  - the next request can be accepted in the cycle after DONE.
- Writes are never interleaved inside a walk. An update arriving mid-walk waits in IDLE arbitration.
- A chain that loops onto itself terminates by the MAX_HOPS timeout.

Test Plan:
- Single-hop hit: table[5] matches the tuple, rule 0x2A; search start=5 -> res_valid at cycle 3, res_hit=1, res_rule_id=0x2A, res_hops=1, res_timeout=0.
- Chain walk: 5->9->12, match at 12, rule 7 -> tbl_index sequence 5, 9, 12; res_valid at cycle 7; res_hops=3, res_hit=1.
- Null link: 5->9, table[9].next=0, no match -> res_hit=0, res_rule_id=0, res_hops=2, res_timeout=0.
- Loop and timeout: MAX_HOPS=4, chain 3->4->3; no match -> res_hops=4, res_timeout=1, res_hit=0.
- Starvation guard: UPD_BURST=4; upd_valid and srch_valid both held high -> exactly 4 update grants (tbl_we pulses at indices 10..13), then a search grant, then updates resume.
- Update-then-search coherence and reset:
  - write table[20] with a matching entry, rule 0x55, then search start=20 -> res_rule_id=0x55.
  - rst_n=0 during WAIT -> next cycle busy=0, tbl_we=0, no res_valid.
